// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing PIO input port.
package pio_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE encodings
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave bus signals for the PIO input port.
interface pio_in_edge_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser, post-reset priming counter and per-bit edge detect.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] detect
);

  localparam logic [2:0] PrimeMax = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES*WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             sync_prev_q;
  logic [2:0]                   prime_q;
  logic                         primed;
  logic [WIDTH-1:0]             rise;
  logic [WIDTH-1:0]             fall;

  assign sync_data = chain_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign primed    = (prime_q == PrimeMax);

  // Shift in_port through the synchroniser and keep one delayed copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q     <= '0;
      sync_prev_q <= '0;
    end else begin
      chain_q     <= {chain_q[(SYNC_STAGES-1)*WIDTH-1:0], in_port};
      sync_prev_q <= sync_data;
    end
  end

  // Saturating counter: covers the cycles where the chain still holds reset zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q <= '0;
    end else if (!primed) begin
      prime_q <= prime_q + 3'd1;
    end
  end

  // Select the edge flavour; nothing is reported until the chain is primed.
  always_comb begin
    rise   = sync_data & ~sync_prev_q;
    fall   = ~sync_data & sync_prev_q;
    detect = '0;
    if (primed) begin
      if (EDGE_TYPE == EDGE_FALL) begin
        detect = fall;
      end else if (EDGE_TYPE == EDGE_ANY) begin
        detect = rise | fall;
      end else begin
        detect = rise;
      end
    end
  end

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM PIO input with synchroniser, edge capture (W1C), IRQ mask and level IRQ.
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter logic [31:0] RESET_MASK  = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  pio_in_edge_capture_if.slave   bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic             irq_q;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits are meaningless when WIDTH < 32.
  assign unused_wdata = ^bus.writedata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .sync_data (sync_data),
    .detect    (detect)
  );

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Write decode and next-state for mask and edge capture; a new edge beats a clear.
  always_comb begin
    edge_clr = '0;
    mask_d   = mask_q;
    if (wr_en && bus.address == ADDR_EDGE) begin
      edge_clr = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && bus.address == ADDR_MASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | detect;
  end

  // Read mux, zero-filled above WIDTH.
  always_comb begin
    rd_mux = '0;
    unique case (bus.address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = sync_data;
      ADDR_MASK: rd_mux[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_q;
      default:   rd_mux = '0;
    endcase
  end

  // Register file, registered read data and registered irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= RESET_MASK[WIDTH-1:0];
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= rd_mux;
      irq_q      <= |(edge_q & mask_q);
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
